// File: rtl/multi_word_parity.sv
// Sequential parity engine. Streams NUM_WORDS word pairs per frame, emits a
// registered per-beat pair parity, and at frame end emits column parity over
// every word of the frame plus a single reduced frame-parity bit. Even/odd
// mode is captured at start and applies to every output of that frame.
module multi_word_parity #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  odd_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] word_a,
  input  logic [DATA_WIDTH-1:0] word_b,
  output logic [DATA_WIDTH-1:0] pair_parity,
  output logic                  pair_valid,
  output logic [DATA_WIDTH-1:0] col_parity,
  output logic                  frame_parity,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err
);

  // One extra bit so the count can reach NUM_WORDS without wrapping.
  localparam int                CNT_W     = $clog2(NUM_WORDS) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    mode;
  logic [DATA_WIDTH-1:0]   acc;
  logic [CNT_W-1:0]        cnt;

  logic                    accept;
  logic                    last_beat;
  logic [DATA_WIDTH-1:0]   pair_xor;
  logic [DATA_WIDTH-1:0]   acc_next;
  logic [DATA_WIDTH-1:0]   mode_mask;

  assign accept    = (state == S_ACCUM) && in_valid;
  assign last_beat = accept && (cnt == LAST_BEAT);
  assign pair_xor  = word_a ^ word_b;
  assign acc_next  = acc ^ pair_xor;
  assign mode_mask = {DATA_WIDTH{mode}};

  assign in_ready  = (state == S_ACCUM);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // State register.
  // NOTE: the reset is in the sensitivity list, so it takes effect without a
  // clock edge; every flop in this block returns to its reset value at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: IDLE -> ACCUM on start, ACCUM -> DONE on last beat,
  // DONE always returns to IDLE after one cycle.
  // NOTE: state_next is given a value before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start)     state_next = S_ACCUM;
      S_ACCUM: if (last_beat) state_next = S_DONE;
      S_DONE:                 state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  // Datapath: mode capture, accumulator, beat count and registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode         <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      pair_parity  <= '0;
      pair_valid   <= 1'b0;
      col_parity   <= '0;
      frame_parity <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      pair_valid <= accept;
      // start outside IDLE (ACCUM or DONE) is ignored but flagged.
      start_err  <= start && (state != S_IDLE);

      if ((state == S_IDLE) && start) begin
        mode <= odd_mode;
        acc  <= '0;
        cnt  <= '0;
      end

      if (accept) begin
        pair_parity <= pair_xor ^ mode_mask;
        acc         <= acc_next;
        cnt         <= cnt + 1'b1;
      end

      // Frame results are registered on the last beat so they are valid in
      // the DONE cycle and hold until the next frame completes.
      if (last_beat) begin
        col_parity   <= acc_next ^ mode_mask;
        frame_parity <= (^acc_next) ^ mode;
      end
    end
  end

endmodule

// File: tb/tb_multi_word_parity.sv
// Bench for multi_word_parity. Three instances (NUM_WORDS = 1, 4, 7) share
// stimulus; a behavioural model checks all of them every cycle, and the
// NUM_WORDS=4 instance is also checked against hand-computed vectors.
module tb_multi_word_parity;

  logic       clk;
  logic       reset;
  logic       start;
  logic       odd_mode;
  logic       in_valid;
  logic [7:0] word_a;
  logic [7:0] word_b;

  logic       ready_o [3];
  logic [7:0] pp_o    [3];
  logic       pv_o    [3];
  logic [7:0] col_o   [3];
  logic       fp_o    [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       serr_o  [3];

  int checks;
  int errors;

  // Model state per instance (state: 0 idle, 1 accum, 2 done).
  int         m_state  [3];
  int         m_cnt    [3];
  int         m_frames [3];
  logic       m_mode   [3];
  logic [7:0] m_acc    [3];
  logic [7:0] m_pp     [3];
  logic       m_pv     [3];
  logic [7:0] m_col    [3];
  logic       m_fp     [3];
  logic       m_serr   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multi_word_parity #(
      .DATA_WIDTH (8),
      .NUM_WORDS  ((g == 0) ? 1 : (g == 1) ? 4 : 7)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .odd_mode     (odd_mode),
      .in_valid     (in_valid),
      .in_ready     (ready_o[g]),
      .word_a       (word_a),
      .word_b       (word_b),
      .pair_parity  (pp_o[g]),
      .pair_valid   (pv_o[g]),
      .col_parity   (col_o[g]),
      .frame_parity (fp_o[g]),
      .busy         (busy_o[g]),
      .done         (done_o[g]),
      .start_err    (serr_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       odd;
    logic       iv;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       pv;
    logic [7:0] pp;
    logic       done;
    logic [7:0] col;
    logic       fp;
    logic       serr;
  } vec_t;

  function automatic vec_t v(input logic s, o, i, input logic [7:0] a, b,
                             input logic rdy, pv, input logic [7:0] pp,
                             input logic dn, input logic [7:0] col,
                             input logic fp, serr);
    vec_t r;
    r.start = s;   r.odd = o;   r.iv = i;     r.a = a;     r.b = b;
    r.ready = rdy; r.pv = pv;   r.pp = pp;    r.done = dn; r.col = col;
    r.fp = fp;     r.serr = serr;
    return r;
  endfunction

  function automatic int nw(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 7;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_state[k] = 0; m_cnt[k] = 0; m_mode[k] = 1'b0; m_acc[k] = '0;
      m_pp[k] = '0;   m_pv[k] = 1'b0; m_col[k] = '0; m_fp[k] = 1'b0;
      m_serr[k] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] x;
      logic [7:0] mask;
      x         = word_a ^ word_b;
      mask      = {8{m_mode[k]}};
      m_serr[k] = start && (m_state[k] != 0);
      m_pv[k]   = 1'b0;
      case (m_state[k])
        0: if (start) begin
          m_mode[k]  = odd_mode;
          m_acc[k]   = '0;
          m_cnt[k]   = 0;
          m_state[k] = 1;
        end
        1: if (in_valid) begin
          m_pp[k]  = x ^ mask;
          m_pv[k]  = 1'b1;
          m_acc[k] = m_acc[k] ^ x;
          if (m_cnt[k] == nw(k) - 1) begin
            m_col[k]   = m_acc[k] ^ mask;
            m_fp[k]    = (^m_acc[k]) ^ m_mode[k];
            m_state[k] = 2;
            m_frames[k]++;
          end else begin
            m_cnt[k]++;
          end
        end
        default: m_state[k] = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d.in_ready", k),     ready_o[k], m_state[k] == 1);
      check($sformatf("u%0d.busy", k),         busy_o[k],  m_state[k] != 0);
      check($sformatf("u%0d.done", k),         done_o[k],  m_state[k] == 2);
      check($sformatf("u%0d.pair_valid", k),   pv_o[k],    m_pv[k]);
      check($sformatf("u%0d.pair_parity", k),  pp_o[k],    m_pp[k]);
      check($sformatf("u%0d.col_parity", k),   col_o[k],   m_col[k]);
      check($sformatf("u%0d.frame_parity", k), fp_o[k],    m_fp[k]);
      check($sformatf("u%0d.start_err", k),    serr_o[k],  m_serr[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  // Called 1 time unit after a rising edge; releases reset well before the next edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    reset = 1'b0;
  endtask

  task automatic drive(input logic s, o, i, input logic [7:0] a, b);
    start = s; odd_mode = o; in_valid = i; word_a = a; word_b = b;
  endtask

  vec_t vecs [22];

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 3; k++) m_frames[k] = 0;
    reset = 1'b1;
    drive(0, 0, 0, 8'h00, 8'h00);

    //            st od iv  a      b      rdy pv pp     dn col    fp se
    // Even frame
    vecs[0]  = v(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 0);
    vecs[1]  = v(0, 0, 1, 8'hFF, 8'h0F, 1, 1, 8'hF0, 0, 8'h00, 0, 0);
    vecs[2]  = v(0, 0, 1, 8'h01, 8'h00, 1, 1, 8'h01, 0, 8'h00, 0, 0);
    vecs[3]  = v(0, 0, 1, 8'hAA, 8'h55, 1, 1, 8'hFF, 0, 8'h00, 0, 0);
    vecs[4]  = v(0, 0, 1, 8'h00, 8'h00, 0, 1, 8'h00, 1, 8'h0E, 1, 0);
    vecs[5]  = v(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h0E, 1, 0);
    // Odd frame; odd_mode drops mid-frame and must be ignored
    vecs[6]  = v(1, 1, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h0E, 1, 0);
    vecs[7]  = v(0, 0, 1, 8'hFF, 8'h0F, 1, 1, 8'h0F, 0, 8'h0E, 1, 0);
    vecs[8]  = v(0, 0, 1, 8'h01, 8'h00, 1, 1, 8'hFE, 0, 8'h0E, 1, 0);
    vecs[9]  = v(0, 0, 1, 8'hAA, 8'h55, 1, 1, 8'h00, 0, 8'h0E, 1, 0);
    vecs[10] = v(0, 0, 1, 8'h00, 8'h00, 0, 1, 8'hFF, 1, 8'hF1, 0, 0);
    vecs[11] = v(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 0, 8'hF1, 0, 0);
    // start with in_valid in IDLE: the beat is not taken; then back-pressure
    vecs[12] = v(1, 0, 1, 8'h11, 8'h22, 1, 0, 8'hFF, 0, 8'hF1, 0, 0);
    vecs[13] = v(0, 0, 1, 8'h01, 8'h02, 1, 1, 8'h03, 0, 8'hF1, 0, 0);
    vecs[14] = v(0, 0, 0, 8'hFF, 8'h00, 1, 0, 8'h03, 0, 8'hF1, 0, 0);
    vecs[15] = v(0, 0, 0, 8'hFF, 8'h00, 1, 0, 8'h03, 0, 8'hF1, 0, 0);
    vecs[16] = v(0, 0, 1, 8'h04, 8'h08, 1, 1, 8'h0C, 0, 8'hF1, 0, 0);
    // start in ACCUM -> start_err, frame unaffected
    vecs[17] = v(1, 1, 0, 8'h77, 8'h00, 1, 0, 8'h0C, 0, 8'hF1, 0, 1);
    vecs[18] = v(0, 0, 1, 8'h10, 8'h20, 1, 1, 8'h30, 0, 8'hF1, 0, 0);
    vecs[19] = v(0, 0, 1, 8'h40, 8'h80, 0, 1, 8'hC0, 1, 8'hFF, 0, 0);
    // start in DONE -> start_err, no new frame
    vecs[20] = v(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'hC0, 0, 8'hFF, 0, 1);
    vecs[21] = v(0, 0, 1, 8'h33, 8'h00, 0, 0, 8'hC0, 0, 8'hFF, 0, 0);

    // Power-on reset spans the first rising edge.
    #12;
    model_reset();
    compare_all();
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].start, vecs[i].odd, vecs[i].iv, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d.in_ready", i),     ready_o[1], vecs[i].ready);
      check($sformatf("vec%0d.pair_valid", i),   pv_o[1],    vecs[i].pv);
      check($sformatf("vec%0d.pair_parity", i),  pp_o[1],    vecs[i].pp);
      check($sformatf("vec%0d.done", i),         done_o[1],  vecs[i].done);
      check($sformatf("vec%0d.col_parity", i),   col_o[1],   vecs[i].col);
      check($sformatf("vec%0d.frame_parity", i), fp_o[1],    vecs[i].fp);
      check($sformatf("vec%0d.start_err", i),    serr_o[1],  vecs[i].serr);
    end

    // Reset after two beats of a frame: everything clears, and the next frame
    // result does not include the lost beats.
    drive(1, 0, 0, 8'h00, 8'h00); step();
    drive(0, 0, 1, 8'hFF, 8'h00); step();
    drive(0, 0, 1, 8'h0F, 8'h00); step();
    drive(0, 0, 0, 8'h00, 8'h00);
    do_reset();
    check("rst.busy",         busy_o[1],  1'b0);
    check("rst.in_ready",     ready_o[1], 1'b0);
    check("rst.pair_parity",  pp_o[1],    8'h00);
    check("rst.col_parity",   col_o[1],   8'h00);
    check("rst.frame_parity", fp_o[1],    1'b0);
    drive(0, 0, 0, 8'h00, 8'h00); step();
    check("rst.no_done", done_o[1], 1'b0);
    drive(1, 0, 0, 8'h00, 8'h00); step();
    drive(0, 0, 1, 8'h12, 8'h00); step();
    drive(0, 0, 1, 8'h00, 8'h34); step();
    drive(0, 0, 1, 8'h00, 8'h00); step();
    check("rst.pre_done", done_o[1], 1'b0);
    drive(0, 0, 1, 8'h00, 8'h00); step();
    check("rst.done",         done_o[1], 1'b1);
    check("rst.col_parity",   col_o[1],  8'h26);
    check("rst.frame_parity", fp_o[1],   1'b1);

    // Random traffic on all three instances until each has finished 1000 frames.
    for (int k = 0; k < 3; k++) m_frames[k] = 0;
    begin
      int cyc;
      cyc = 0;
      while ((m_frames[0] < 1000 || m_frames[1] < 1000 || m_frames[2] < 1000) && cyc < 60000) begin
        drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
        step();
        if ($urandom_range(0, 499) == 0) do_reset();
        cyc++;
      end
      check("random.frames_done", (cyc < 60000), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
